// File: rtl/serial_load_scheduler.sv
// rtl/serial_load_scheduler.sv - OSD download to ACIA RXD 8N1 serialiser with FIFO, pacing and source select (optional: SERIAL_LOAD_LF_TO_CR_EN)
module serial_load_scheduler #(
  parameter int CLK_HZ        = 50000000,
  parameter int FIFO_DEPTH    = 16,
  parameter int CHAR_GAP_BITS = 2,
  parameter int LINE_GAP_BITS = 200
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       load_from,
  input  logic       baud_rate,
  input  logic       ioctl_download,
  input  logic       ioctl_wr,
  input  logic [7:0] ioctl_data,
  output logic       ioctl_wait,
  input  logic       uart_rxd,
  output logic       rxd_out,
  output logic       busy,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] WAIT_C   = CW'(FIFO_DEPTH - 1);
  localparam logic [17:0]   BIT_9600 = 18'(CLK_HZ / 9600);
  localparam logic [17:0]   BIT_300  = 18'(CLK_HZ / 300);
  localparam logic [15:0]   GAP_CHAR = 16'(CHAR_GAP_BITS);
  localparam logic [15:0]   GAP_LINE = 16'(CHAR_GAP_BITS + LINE_GAP_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;
  state_t state, state_next;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          full, wr_req, wr_en, pop;
  logic [7:0]    wr_byte;
  logic          drop_lf;

  logic          sel;
  logic [17:0]   bit_cyc, cyc_cnt;
  logic [2:0]    bit_idx;
  logic [15:0]   gap_cnt, gap_len;
  logic [7:0]    shreg;
  logic          was_cr, tick, gap_done, ser_line;

`ifdef SERIAL_LOAD_LF_TO_CR_EN
  logic last_cr;

  // Newline folding and upper-casing; the CR flag is held clear while no download runs
  always_comb begin
    wr_byte = ioctl_data;
    drop_lf = 1'b0;
    if (ioctl_data == 8'h0A) begin
      if (last_cr) drop_lf = 1'b1;
      else         wr_byte = 8'h0D;
    end else if (ioctl_data >= 8'h61 && ioctl_data <= 8'h7A) begin
      wr_byte = ioctl_data - 8'h20;
    end
  end

  // Remember whether the last download byte offered was a CR
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                    last_cr <= 1'b0;
    else if (!ioctl_download)        last_cr <= 1'b0;
    else if (ioctl_wr)               last_cr <= (ioctl_data == 8'h0D);
  end
`else
  assign wr_byte = ioctl_data;
  assign drop_lf = 1'b0;
`endif

  assign full     = (count == DEPTH_C);
  assign wr_req   = ioctl_download && ioctl_wr && !drop_lf;
  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands
  assign wr_en    = wr_req && (!full || pop);
  assign tick     = (cyc_cnt == bit_cyc - 18'd1);
  assign gap_len  = was_cr ? GAP_LINE : GAP_CHAR;
  assign gap_done = ((gap_cnt + 16'd1) >= gap_len);

  // FIFO occupancy after this cycle's write/pop
  always_comb begin
    count_next = count;
    case ({wr_en, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Serialiser next state and line level
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    ser_line   = 1'b1;
    case (state)
      S_IDLE:  if (!sel && count != '0) begin
                 pop        = 1'b1;
                 state_next = S_START;
               end
      S_START: begin
                 ser_line = 1'b0;
                 if (tick) state_next = S_DATA;
               end
      S_DATA:  begin
                 ser_line = shreg[0];
                 if (tick && bit_idx == 3'd7) state_next = S_STOP;
               end
      S_STOP:  if (tick) state_next = (gap_len == 16'd0) ? S_IDLE : S_GAP;
      S_GAP:   if (tick && gap_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= S_IDLE;
    else          state <= state_next;
  end

  // FIFO pointers, fill level, HPS throttle and sticky overflow
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ioctl_wait <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count      <= count_next;
      ioctl_wait <= (count_next >= WAIT_C);
      if (wr_req && !wr_en) overflow <= 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_byte;
  end

  // Bit timer, shift register and gap counter; baud is fixed per frame at pop
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cyc_cnt <= '0;
      bit_cyc <= BIT_9600;
      bit_idx <= '0;
      gap_cnt <= '0;
      shreg   <= '0;
      was_cr  <= 1'b0;
    end else begin
      if (state == S_IDLE || tick) cyc_cnt <= '0;
      else                         cyc_cnt <= cyc_cnt + 18'd1;
      if (pop) begin
        shreg   <= mem[rd_ptr];
        was_cr  <= (mem[rd_ptr] == 8'h0D);
        bit_idx <= '0;
        bit_cyc <= baud_rate ? BIT_300 : BIT_9600;
      end else if (state == S_DATA && tick) begin
        shreg   <= {1'b0, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (state == S_STOP)             gap_cnt <= '0;
      else if (state == S_GAP && tick) gap_cnt <= gap_cnt + 16'd1;
    end
  end

  // Source select changes only between frames; output mux and busy are registered together
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sel     <= 1'b0;
      rxd_out <= 1'b1;
      busy    <= 1'b0;
    end else begin
      if (state == S_IDLE && !pop) sel <= load_from;
      rxd_out <= sel ? uart_rxd : ser_line;
      busy    <= (count != '0) || (state != S_IDLE);
    end
  end

endmodule

// File: doc/serial_load_scheduler.md
Name: serial_load_scheduler

Overview:
- Schedules byte delivery from the OSD "Load Ascii" file download into the UK101 ACIA receive line.
- Buffers ioctl_wr bytes in a FIFO and throttles the HPS with ioctl_wait.
- Re-serialises each byte as 8N1 at the selected baud, with inter-character and end-of-line pacing so BASIC/monitor can keep up.
- Arbitrates the ACIA RXD input between this serialiser and the external UART_RXD pin per the "Load programs from" setting. Sits in emu between hps_io and uk101.

Parameters:
- CLK_HZ, 50000000: clk frequency in Hz.
- FIFO_DEPTH, 16: buffer entries, power of 2, ≥4.
- CHAR_GAP_BITS, 2: extra idle (mark) bit periods after each stop bit.
- LINE_GAP_BITS, 200: extra idle bit periods after a transmitted CR (0x0D).

Ports:
- clk, in, 1: system clock.
- n_reset, in, 1: asynchronous active-low reset.
- load_from, in, 1: 0 = file/serialiser drives RXD, 1 = uart_rxd drives RXD.
- baud_rate, in, 1: 0 = 9600, 1 = 300.
- ioctl_download, in, 1: download active.
- ioctl_wr, in, 1: byte strobe, one cycle.
- ioctl_data, in, 8: download byte.
- ioctl_wait, out, 1: stall HPS.
- uart_rxd, in, 1: external serial input.
- rxd_out, out, 1: line to the ACIA rxd.
- busy, out, 1: FIFO non-empty or frame/gap in progress.
- overflow, out, 1: sticky, a write was dropped.

Behaviour:
- Reset (async, n_reset=0):
  - Outputs: rxd_out=1, ioctl_wait=0, busy=0, overflow=0.
  - State: FIFO empty, FSM IDLE, sel=load_from sampled after release.
- Bit period:
  - BIT_CYC = CLK_HZ/9600 (5208) or CLK_HZ/300 (166666), integer truncation; 18-bit counter.
  - baud_rate is latched at START entry; changes mid-frame take effect next frame.
- FIFO write:
  - Accepts a byte when ioctl_download=1, ioctl_wr=1 and the FIFO is not full.
  - ioctl_wr while ioctl_download=0 is ignored.
  - Write when full: byte dropped, overflow set (cleared only by reset).
  - Simultaneous read and write when full: the write is accepted.
- ioctl_wait: registered, =1 when count ≥ FIFO_DEPTH-1, so it asserts one cycle ahead of full.
- FSM states (all transitions on bit-period expiry unless noted):
  - IDLE: line = 1. If sel=0 and FIFO non-empty: pop into the shift register, go to START.
  - START: line = 0 for 1 bit, then DATA.
  - DATA: 8 bits, LSB first, bit counter 0..7, then STOP.
  - STOP: line = 1 for 1 bit, then GAP.
  - GAP: line = 1 for CHAR_GAP_BITS bits, or CHAR_GAP_BITS+LINE_GAP_BITS if the byte was 0x0D, then IDLE.
- Source select:
  - sel updates from load_from only in IDLE. A mid-frame switch completes the frame first, so no glitch is seen on the ACIA.
  - rxd_out = sel ? uart_rxd : serialiser line, registered (1-cycle latency).
  - While sel=1 the FIFO holds its contents and ioctl_wait still follows FIFO fill.
- busy = (FIFO count ≠ 0) || (state ≠ IDLE).
- A download ending (ioctl_download 1→0) does not flush; buffered bytes still drain.
- Reset mid-frame aborts immediately; rxd_out returns to 1 asynchronously.

Optional Feature:
- Macro: SERIAL_LOAD_LF_TO_CR_EN.
- Defined: newline translation at FIFO write.
  - 0x0A following a written 0x0D is dropped (not stored, no overflow).
  - 0x0A following anything else is stored as 0x0D.
  - Bytes 0x61–0x7A are stored upper-cased (−0x20).
  - The last-byte-was-CR flag resets to 0 at reset and on ioctl_download rising.
- Undefined: bytes stored verbatim.

Test Plan:
- Reset, baud_rate=0, load_from=0; write 0x41 → rxd_out low 5208 cycles, then bits 1,0,0,0,0,0,1,0 at 5208 each, stop high, busy falls 3×5208 cycles after the start of the stop bit.
- Write 20 bytes back-to-back, honouring ioctl_wait → ioctl_wait rises when count reaches 15; all 20 bytes appear in order; overflow=0.
- Write 17 bytes ignoring ioctl_wait, no pop possible (load_from=1) → 16 stored, overflow=1.
- Toggle load_from 0→1 during DATA of 0x55 → frame completes intact, then rxd_out follows uart_rxd one cycle delayed.
- baud_rate=1, write 0x0D → bit period 166666; idle gap after stop is 202 bit periods before the next start bit.
- With SERIAL_LOAD_LF_TO_CR_EN: write 0x0D,0x0A,0x61,0x0A → transmitted 0x0D,0x41,0x0D. Without the macro: transmitted 0x0D,0x0A,0x61,0x0A.
